// File: rtl/mem_arbiter.sv
// mem_arbiter: grants one of two requesters (fetch / data) and sequences the MAR/MDR/RAM strobes for a single access.
// Latency: request sampled in IDLE at cycle 0, done pulses in cycle 4 for reads and writes alike.
// Backpressure: requests are sampled only in IDLE; a losing or busy requester just keeps req high until served.
// Config macro: MEM_ARB_FETCH_PRIO_EN selects fixed fetch priority instead of round-robin.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic [15:0] f_rdata,
    output logic        f_done,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic [15:0] bus_out,
    output logic        gate_arb,
    output logic        ldMAR,
    output logic        ldMDR,
    output logic        selMDR,
    output logic        memWE,
    input  logic [15:0] mdr_q,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAR   = 3'd1,
        WAIT  = 3'd2,
        LDMDR = 3'd3,
        MDRW  = 3'd4,
        WR    = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // Transaction context frozen at grant time so requester changes cannot leak in.
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic        we_q;
    logic        gnt_data_q;

    logic        pick_data;
    logic        grant;

    assign grant = (state == IDLE) && (f_req || d_req);

`ifdef MEM_ARB_FETCH_PRIO_EN
    // Fixed priority: data only wins when fetch is not asking.
    assign pick_data = d_req && !f_req;
`else
    logic last_data;

    // Round-robin: on a tie the port not served last wins.
    assign pick_data = d_req && (!f_req || !last_data);

    // Remember who was served last; reset favours fetch on the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_data <= 1'b1;
        end else if (grant) begin
            last_data <= pick_data;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the winner's request at grant; fetch is always a read.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            gnt_data_q <= 1'b0;
        end else if (grant) begin
            addr_q     <= pick_data ? d_addr : f_addr;
            wdata_q    <= d_wdata;
            we_q       <= pick_data && d_we;
            gnt_data_q <= pick_data;
        end
    end

    // Read data is returned to the granted port only on read completion and held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_rdata <= 16'h0000;
            d_rdata <= 16'h0000;
        end else if (state == DONE && !we_q) begin
            if (gnt_data_q) begin
                d_rdata <= mdr_q;
            end else begin
                f_rdata <= mdr_q;
            end
        end
    end

    // Next-state and Moore strobe decode; everything idles low unless the state drives it.
    always_comb begin
        state_nxt = state;
        bus_out   = 16'h0000;
        gate_arb  = 1'b0;
        ldMAR     = 1'b0;
        ldMDR     = 1'b0;
        selMDR    = 1'b0;
        memWE     = 1'b0;
        f_done    = 1'b0;
        d_done    = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (f_req || d_req) begin
                    state_nxt = MAR;
                end
            end
            MAR: begin
                bus_out   = addr_q;
                gate_arb  = 1'b1;
                ldMAR     = 1'b1;
                state_nxt = we_q ? MDRW : WAIT;
            end
            WAIT: begin
                // Synchronous RAM needs a cycle after MAR loads before its output is valid.
                state_nxt = LDMDR;
            end
            LDMDR: begin
                ldMDR     = 1'b1;
                selMDR    = 1'b1;
                state_nxt = DONE;
            end
            MDRW: begin
                bus_out   = wdata_q;
                gate_arb  = 1'b1;
                ldMDR     = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                memWE     = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                f_done    = !gnt_data_q;
                d_done    = gnt_data_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives mem_arbiter against a behavioural MAR/MDR/RAM block and a transaction-level reference.
// Latency: each transaction is checked cycle by cycle from grant to the idle cycle after done.
// Backpressure: requests are presented in IDLE and optionally held, dropped or perturbed mid-flight.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req;
    logic [15:0] f_addr;
    logic [15:0] f_rdata;
    logic        f_done;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_done;
    logic [15:0] bus_out;
    logic        gate_arb;
    logic        ldMAR;
    logic        ldMDR;
    logic        selMDR;
    logic        memWE;
    logic [15:0] mdr_q;
    logic        busy;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_done(f_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done),
        .bus_out(bus_out), .gate_arb(gate_arb),
        .ldMAR(ldMAR), .ldMDR(ldMDR), .selMDR(selMDR), .memWE(memWE),
        .mdr_q(mdr_q), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory block: MAR, MDR and a synchronous RAM, plus a preload port for the bench.
    logic [15:0] ram [0:65535];
    logic [15:0] mar;
    logic [15:0] ram_dout;
    logic [15:0] bus;
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [15:0] pre_dat;

    assign bus   = gate_arb ? bus_out : 16'h0000;
    assign mdr_q = mdr_reg;
    logic [15:0] mdr_reg;

    always @(posedge clk) begin
        if (pre_we) ram[pre_addr] <= pre_dat;
        else if (memWE) ram[mar] <= mdr_reg;
        if (ldMAR) mar <= bus;
        if (ldMDR) mdr_reg <= selMDR ? ram_dout : bus;
        ram_dout <= ram[mar];
    end

    // Reference state: memory image, per-port read data, last winner.
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] ref_f;
    logic [15:0] ref_d;
    logic        last_data_m;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] strobes();
        return {gate_arb, ldMAR, ldMDR, selMDR, memWE};
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_dat = v;
        @(negedge clk);
        pre_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
    task automatic run_txn(input logic fr, input logic [15:0] fa, input logic dr, input logic dwe,
                           input logic [15:0] da, input logic [15:0] dwd,
                           input logic hold, input logic perturb, input logic [15:0] p_addr);
        logic        win_d;
        logic        ex_we;
        logic [15:0] ex_addr;
        f_req = fr; f_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
`ifdef MEM_ARB_FETCH_PRIO_EN
        win_d = dr && !fr;
`else
        win_d = dr && (!fr || !last_data_m);
`endif
        last_data_m = win_d;
        ex_we   = win_d && dwe;
        ex_addr = win_d ? da : fa;

        @(posedge clk); @(negedge clk);              // cycle 1
        chk("c1_strobe", 32'(strobes()), 32'b11000);
        chk("c1_bus", 32'(bus_out), 32'(ex_addr));
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_done", 32'({f_done, d_done}), 32'd0);
        if (!hold) begin
            f_req = 1'b0; d_req = 1'b0;
        end
        if (perturb) begin
            f_addr = ~fa; d_addr = p_addr; d_wdata = ~dwd; d_we = ~dwe;
        end

        @(posedge clk); @(negedge clk);              // cycle 2
        chk("c2_strobe", 32'(strobes()), ex_we ? 32'b10100 : 32'b00000);
        chk("c2_bus", 32'(bus_out), ex_we ? 32'(dwd) : 32'd0);
        chk("c2_done", 32'({f_done, d_done}), 32'd0);

        @(posedge clk); @(negedge clk);              // cycle 3
        chk("c3_strobe", 32'(strobes()), ex_we ? 32'b00001 : 32'b00110);
        chk("c3_bus", 32'(bus_out), 32'd0);

        @(posedge clk); @(negedge clk);              // cycle 4
        chk("c4_strobe", 32'(strobes()), 32'd0);
        chk("c4_done", 32'({f_done, d_done}), win_d ? 32'b01 : 32'b10);
        chk("c4_busy", 32'(busy), 32'd1);
        if (ex_we) ref_mem[ex_addr] = dwd;
        else if (win_d) ref_d = ref_mem[ex_addr];
        else ref_f = ref_mem[ex_addr];

        @(posedge clk); @(negedge clk);              // idle again
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'({f_done, d_done}), 32'd0);
        chk("idle_strobe", 32'(strobes()), 32'd0);
        chk("f_rdata", 32'(f_rdata), 32'(ref_f));
        chk("d_rdata", 32'(d_rdata), 32'(ref_d));
        if (ex_we) chk("mem_write", 32'(ram[ex_addr]), 32'(dwd));
    endtask

    initial begin
        reset = 1'b1;
        f_req = 1'b0; f_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        ref_f = '0; ref_d = '0; last_data_m = 1'b1;

        preload(16'h3000, 16'hBEEF);
        preload(16'h5000, 16'hA5A5);
        @(negedge clk);
        chk("rst_strobe", 32'(strobes()), 32'd0);
        chk("rst_bus", 32'(bus_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'({f_done, d_done}), 32'd0);
        chk("rst_f_rdata", 32'(f_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fetch read of a preloaded word.
        run_txn(1'b1, 16'h3000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("fetch_beef", 32'(f_rdata), 32'hBEEF);
        // Data write then read back; fetch data must stay put.
        run_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h4001, 16'h1234, 1'b0, 1'b0, 16'h0);
        run_txn(1'b0, 16'h0, 1'b1, 1'b0, 16'h4001, 16'h0, 1'b0, 1'b0, 16'h0);
        chk("data_1234", 32'(d_rdata), 32'h1234);
        chk("fetch_held", 32'(f_rdata), 32'hBEEF);
        // Address change mid-write must not redirect the write.
        run_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h4002, 16'h7777, 1'b0, 1'b1, 16'h5000);
        chk("mem_4002", 32'(ram[16'h4002]), 32'h7777);
        chk("mem_5000", 32'(ram[16'h5000]), 32'hA5A5);

        // Fill the random window through the data port.
        for (int i = 0; i < 16; i++)
            run_txn(1'b0, 16'h0, 1'b1, 1'b1, 16'h4000 + 16'(i), 16'($urandom), 1'b0, 1'b0, 16'h0);

        // Reset in cycle 2 of a write abandons it.
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h4005; d_wdata = ~ref_mem[16'h4005];
        @(posedge clk); @(negedge clk);
        d_req = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_mid_strobe", 32'(strobes()), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        ref_f = '0; ref_d = '0; last_data_m = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rst_mid_done", 32'({f_done, d_done}), 32'd0);
            chk("rst_mid_we", 32'(memWE), 32'd0);
        end
        chk("rst_mid_mem", 32'(ram[16'h4005]), 32'(ref_mem[16'h4005]));

        // Both requesters held high for three grants.
        for (int i = 0; i < 3; i++)
            run_txn(1'b1, 16'h4003, 1'b1, 1'b0, 16'h4004, 16'h0, 1'b1, 1'b0, 16'h0);
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Randomized traffic over the initialised window.
        for (int i = 0; i < 60; i++) begin
            logic fr;
            logic dr;
            fr = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!fr && !dr) fr = 1'b1;
            run_txn(fr, 16'h4000 + 16'($urandom_range(0, 15)), dr, 1'($urandom_range(0, 1)),
                    16'h4000 + 16'($urandom_range(0, 15)), 16'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'h5000);
        end
        f_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("final_5000", 32'(ram[16'h5000]), 32'hA5A5);
        for (int a = 0; a < 16; a++)
            chk("final_win", 32'(ram[16'h4000 + 16'(a)]), 32'(ref_mem[16'h4000 + 16'(a)]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
